// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//    Data-memory responder for the MEM phase of a simple CPU. It accepts one
//    word load/store request at a time. It waits a fixed number of cycles and
//    then performs the access against an internal byte-addressed, big-endian
//    memory. It answers with a single-cycle ready pulse.
//
//    The memory is built as four byte lanes, each holding DEPTH/4 bytes.
//    Lane 0 holds the most significant byte of a word, at the lowest byte
//    address. Because accesses are always word aligned (misaligned ones are
//    suppressed), a word never straddles two rows. This lets each lane map
//    onto a plain block RAM with a registered read port.
//
// Parameters:
//    DEPTH   - memory size in bytes (power of two, >= 4)
//    LATENCY - wait cycles between acceptance and response (0..15)
//
// Ports:
//    clk    in   1   single clock, everything changes on the rising edge
//    Reset  in   1   synchronous, active-low reset
//    req    in   1   request strobe, only honoured while idle
//    we     in   1   1 = store word, 0 = load word
//    addr   in  32   byte address (taken modulo DEPTH)
//    wdata  in  32   store data
//    rdata  out 32   load data, meaningful while ready = 1
//    ready  out  1   one-cycle response pulse
//    busy   out  1   high whenever a transaction is in flight
//    err    out  1   misaligned-access flag, meaningful while ready = 1
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int AW    = $clog2(DEPTH);
   localparam int WORDS = DEPTH / 4;
   localparam int IW    = (AW > 2) ? AW - 2 : 1;
   localparam logic [3:0] LAT = 4'(LATENCY);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          ready_q, ready_d;
   logic          err_q, err_d;

   // Access strobe plus the operands used on the access edge.
   logic          acc_fire;
   logic [AW-1:0] acc_addr;
   logic          acc_we;
   logic [31:0]   acc_wdata;
   logic          acc_misaligned;
   logic [IW-1:0] acc_index;
   logic          mem_wr;
   logic          rd_load;
   logic          rd_clear;

   // The upper address bits are discarded by design (wrap-around).
   logic          unused_addr_hi;
   assign unused_addr_hi = ^addr[31:AW];

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      acc_fire  = 1'b0;
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_wdata = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = addr[AW-1:0];
               we_d    = we;
               wdata_d = wdata;
               cnt_d   = LAT;
               if (LAT == 4'd0) begin
                  // Zero latency: the access happens on the acceptance
                  // edge itself, so use the live inputs directly.
                  state_d   = S_RESP;
                  acc_fire  = 1'b1;
                  acc_addr  = addr[AW-1:0];
                  acc_we    = we;
                  acc_wdata = wdata;
                  ready_d   = 1'b1;
                  err_d     = (addr[1:0] != 2'b00);
               end else begin
                  state_d = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            // The counter reaches zero on this edge: access and respond.
            if (cnt_q <= 4'd1) begin
               cnt_d    = 4'd0;
               state_d  = S_RESP;
               acc_fire = 1'b1;
               ready_d  = 1'b1;
               err_d    = (addr_q[1:0] != 2'b00);
            end
         end

         S_RESP: begin
            // Exactly one response cycle, whatever req is doing.
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   // ---------------------------------------------------------------------
   // Access decode
   // ---------------------------------------------------------------------
   assign acc_misaligned = (acc_addr[1:0] != 2'b00);

   generate
      if (AW > 2) begin : g_index
         assign acc_index = acc_addr[AW-1:2];
      end else begin : g_index_single
         assign acc_index = '0;
      end
   endgenerate

   // Reset gates the write, so reset during WAIT aborts a store cleanly.
   assign mem_wr   = acc_fire & acc_we & ~acc_misaligned & Reset;
   assign rd_load  = acc_fire & ~acc_we & ~acc_misaligned;
   assign rd_clear = acc_fire & acc_misaligned;

   // ---------------------------------------------------------------------
   // Byte lanes: lane gi holds byte address offset gi within each word,
   // i.e. data bits [31-8*gi -: 8] (big-endian).
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [WORDS];
         logic [7:0] rd_byte_q;

         // No reset on the array: contents survive reset.
         always_ff @(posedge clk) begin
            if (mem_wr) begin
               lane_mem[acc_index] <= acc_wdata[31-8*gi -: 8];
            end
         end

         // Registered read. It holds between loads; stores leave it alone
         // and misaligned accesses clear it.
         always_ff @(posedge clk) begin
            if (!Reset) begin
               rd_byte_q <= 8'd0;
            end else if (rd_load) begin
               rd_byte_q <= lane_mem[acc_index];
            end else if (rd_clear) begin
               rd_byte_q <= 8'd0;
            end
         end

         assign rdata[31-8*gi -: 8] = rd_byte_q;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign ready = ready_q;
   assign err   = err_q;
   assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder. It uses two instances:
//    dut2 - LATENCY = 2 (table-driven vectors plus corner sequences)
//    dut0 - LATENCY = 0 (immediate response)
// Both instances share the clock and Reset; each has its own request inputs.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        Reset;

   logic        req2, we2;
   logic [31:0] addr2, wdata2, rdata2;
   logic        ready2, busy2, err2;

   logic        req0, we0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        ready0, busy0, err0;

   int errors = 0;
   int checks = 0;

   // Selects which instance the transaction task observes.
   bit          sel0 = 1'b0;
   logic [31:0] s_rdata;
   logic        s_ready, s_busy, s_err;
   assign s_rdata = sel0 ? rdata0 : rdata2;
   assign s_ready = sel0 ? ready0 : ready2;
   assign s_busy  = sel0 ? busy0  : busy2;
   assign s_err   = sel0 ? err0   : err2;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(128), .LATENCY(2)) dut2 (
      .clk(clk), .Reset(Reset), .req(req2), .we(we2), .addr(addr2),
      .wdata(wdata2), .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2)
   );

   data_mem_responder #(.DEPTH(128), .LATENCY(0)) dut0 (
      .clk(clk), .Reset(Reset), .req(req0), .we(we0), .addr(addr0),
      .wdata(wdata0), .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit on0, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      if (on0) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req2 = r; we2 = w; addr2 = a; wdata2 = d;
      end
   endtask

   // One complete transaction. The inputs are scrambled after acceptance,
   // so the response must come from the latched copies.
   task automatic run_txn(input bit on0, input logic t_we, input logic [31:0] t_addr,
                          input logic [31:0] t_wdata, input int exp_lat,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
      int n;
      bit seen;
      sel0 = on0;
      @(negedge clk);
      drive(on0, 1'b1, t_we, t_addr, t_wdata);
      @(posedge clk);
      #1;
      drive(on0, 1'b0, ~t_we, ~t_addr, ~t_wdata);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (s_ready) begin
            seen = 1'b1;
         end else begin
            check({tag, " busy_wait"}, {31'd0, s_busy}, 32'd1);
            check({tag, " err_wait"}, {31'd0, s_err}, 32'd0);
         end
      end
      if (!seen) begin
         check({tag, " ready_timeout"}, 32'd0, 32'd1);
      end else begin
         check({tag, " latency"}, n, exp_lat);
         check({tag, " err"}, {31'd0, s_err}, {31'd0, exp_err});
         check({tag, " rdata"}, s_rdata, exp_rd);
         check({tag, " busy_resp"}, {31'd0, s_busy}, 32'd1);
      end
      @(negedge clk);
      check({tag, " ready_after"}, {31'd0, s_ready}, 32'd0);
      check({tag, " busy_after"}, {31'd0, s_busy}, 32'd0);
      check({tag, " err_after"}, {31'd0, s_err}, 32'd0);
      $display("txn %s we=%0d addr=%h wdata=%h cycles=%0d rdata=%h err=%0d",
               tag, t_we, t_addr, t_wdata, n, s_rdata, s_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           we    addr           wdata          exp_rd         exp_err
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hA1B2_C3D4, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hA1B2_C3D4, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0092, 32'h5566_7788, 32'h0000_0000, 1'b1};
      vecs[4]  = '{1'b0, 32'h0000_0090, 32'h0000_0000, 32'hA1B2_C3D4, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0014, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
      vecs[6]  = '{1'b1, 32'h0000_007C, 32'h1234_5678, 32'hCAFE_F00D, 1'b0};
      vecs[7]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 32'h1234_5678, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_0011, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b1, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[10] = '{1'b0, 32'h1234_5610, 32'h0000_0000, 32'hA1B2_C3D4, 1'b0};
      vecs[11] = '{1'b1, 32'h0000_0016, 32'h9999_9999, 32'h0000_0000, 1'b1};

      Reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset ready", {31'd0, ready2}, 32'd0);
      check("reset busy", {31'd0, busy2}, 32'd0);
      check("reset err", {31'd0, err2}, 32'd0);
      check("reset rdata", rdata2, 32'd0);
      check("reset0 busy", {31'd0, busy0}, 32'd0);
      check("reset0 rdata", rdata0, 32'd0);
      Reset = 1'b1;

      // Table-driven vectors, LATENCY = 2: response 3 cycles after acceptance
      for (int i = 0; i < 12; i++) begin
         run_txn(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, 3,
                 vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
      end

      // req held high: acceptances 4 cycles apart, one ready each
      sel0 = 1'b0;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check($sformatf("hold ready k=%0d", k), {31'd0, ready2}, {31'd0, (k % 4) == 3});
         check($sformatf("hold busy k=%0d", k), {31'd0, busy2}, {31'd0, (k % 4) != 0});
         if ((k % 4) == 3) begin
            check($sformatf("hold rdata k=%0d", k), rdata2, 32'hA1B2_C3D4);
         end
      end
      req2 = 1'b0;
      $display("txn hold_req three responses observed window=12 cycles");

      // Reset during WAIT aborts a store; reset also beats req on that edge
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
      @(posedge clk);
      @(negedge clk);
      check("abort busy_wait", {31'd0, busy2}, 32'd1);
      Reset = 1'b0;
      @(negedge clk);
      check("abort ready", {31'd0, ready2}, 32'd0);
      check("abort busy", {31'd0, busy2}, 32'd0);
      check("abort err", {31'd0, err2}, 32'd0);
      check("abort rdata", rdata2, 32'd0);
      Reset = 1'b1;
      req2 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("abort no_ready k=%0d", k), {31'd0, ready2}, 32'd0);
         check($sformatf("abort idle k=%0d", k), {31'd0, busy2}, 32'd0);
      end
      $display("txn abort store addr=00000020 wdata=deadbeef");
      run_txn(1'b0, 1'b0, 32'h0000_0020, 32'd0, 3, 32'h0000_0000, 1'b0, "abort_load");

      // LATENCY = 0: ready on the cycle right after acceptance
      run_txn(1'b1, 1'b1, 32'h0000_0010, 32'hA1B2_C3D4, 1, 32'h0000_0000, 1'b0, "lat0_store");
      run_txn(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1, 32'hA1B2_C3D4, 1'b0, "lat0_load");
      run_txn(1'b1, 1'b0, 32'h0000_0013, 32'd0, 1, 32'h0000_0000, 1'b1, "lat0_misalign");
      run_txn(1'b1, 1'b0, 32'h0000_0090, 32'd0, 1, 32'hA1B2_C3D4, 1'b0, "lat0_wrap");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
